// File: rtl/data_mem_stage.sv
// Data memory stage: single-port doubleword array serving one ld/sd request at a time.
// Latency: req captured in IDLE, array access on the following edge, done pulses in RESP (one request per 3 cycles).
// Backpressure: busy is high in ACCESS and RESP; req seen while busy is dropped, never queued.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   req               - access request, only sampled in IDLE
//   mem_read/write    - ld / sd select (both set = conflict error, neither = no-op)
//   addr, wdata       - byte address and store data, captured with req
//   busy, done, err   - in-flight flag, one-cycle completion pulse, error (valid with done)
//   rdata             - load result, held until the next completed load or error
module data_mem_stage #(
  parameter int DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [63:0] rdata,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] cap_idx;
  logic          cap_misal;
  logic          cap_rd;
  logic          cap_wr;
  logic [63:0]   cap_wdata;

  // Array is deliberately not reset; contents are undefined until stored.
  logic [63:0]   mem [DEPTH];

  // Bits above the array index only select a wrapped alias of the array.
  logic          addr_hi_unused;
  assign addr_hi_unused = ^addr[63:AW+3];

  logic          op_err;
  logic          do_write;

  assign op_err   = cap_misal || (cap_rd && cap_wr);
  // A reset during ACCESS already forced IDLE, so an aborted store never writes.
  assign do_write = (state == ACCESS) && cap_wr && !op_err;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[cap_idx] <= cap_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 64'd0;
      cap_idx   <= '0;
      cap_misal <= 1'b0;
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_wdata <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req) begin
            cap_idx   <= addr[AW+2:3];
            cap_misal <= (addr[2:0] != 3'd0);
            cap_rd    <= mem_read;
            cap_wr    <= mem_write;
            cap_wdata <= wdata;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          done  <= 1'b1;
          state <= RESP;
          if (op_err) begin
            err   <= 1'b1;
            rdata <= 64'd0;
          end else begin
            err <= 1'b0;
            if (cap_rd) begin
              rdata <= mem[cap_idx];
            end
          end
        end
        RESP: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Testbench for data_mem_stage: directed scenarios plus randomized ld/sd traffic.
// Latency: every request is expected to complete exactly two edges after capture.
// Backpressure: requests issued while busy must be dropped.
module tb_data_mem_stage;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [63:0] addr = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic        busy;
  logic        done;
  logic [63:0] rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: array of doublewords plus the last reported load value.
  logic [63:0] model_mem [DEPTH];
  logic [63:0] exp_rdata = 64'd0;

  data_mem_stage #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // err must never be seen without done.
  always @(negedge clk) begin
    if (!rst && !done) chk("err_without_done", {63'd0, err}, 64'd0);
  end

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  // Model of one completed request, straight from the access rules.
  task automatic model_op(input bit rd, input bit wr, input logic [63:0] a,
                          input logic [63:0] wd, output bit exp_err);
    if (a[2:0] != 3'd0 || (rd && wr)) begin
      exp_err   = 1'b1;
      exp_rdata = 64'd0;
    end else begin
      exp_err = 1'b0;
      if (rd) exp_rdata = model_mem[idx_of(a)];
      else if (wr) model_mem[idx_of(a)] = wd;
    end
  endtask

  // Issue one request from IDLE and check the full 3-cycle response.
  task automatic run_op(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] wd);
    bit e;
    @(negedge clk);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    req = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    @(posedge clk); #1;
    chk("busy_access", {63'd0, busy}, 64'd1);
    chk("done_access", {63'd0, done}, 64'd0);
    // Scramble inputs: the in-flight operation must use the captured copy.
    req = 1'b0;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    model_op(rd, wr, a, wd, e);
    @(posedge clk); #1;
    chk("done_resp", {63'd0, done}, 64'd1);
    chk("busy_resp", {63'd0, busy}, 64'd1);
    chk("err_resp", {63'd0, err}, {63'd0, e});
    chk("rdata_resp", rdata, exp_rdata);
    @(posedge clk); #1;
    chk("done_after", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("rdata_hold", rdata, exp_rdata);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    logic [63:0] busy_addr [6];
    logic [63:0] busy_dat  [6];
    logic [63:0] old8;
    int          n_done;
    bit          exp_busy [6];
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state, with req held high to confirm it is ignored under reset.
    req = 1'b1; mem_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    @(negedge clk);
    req = 1'b0; mem_write = 1'b0; rst = 1'b0;

    // Fill the whole array so every later load has a defined value.
    for (int i = 0; i < DEPTH; i++) run_op(1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom});

    // Store then load.
    run_op(1'b0, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D);
    run_op(1'b1, 1'b0, 64'h40, 64'd0);
    chk("ld_0x40", rdata, 64'hDEADBEEF_CAFEF00D);

    // Misaligned store errors and leaves the array alone.
    run_op(1'b0, 1'b1, 64'h44, 64'h1111);
    chk("misal_rdata", rdata, 64'd0);
    run_op(1'b1, 1'b0, 64'h40, 64'd0);
    chk("ld_after_misal", rdata, 64'hDEADBEEF_CAFEF00D);

    // Address wrap modulo DEPTH*8 bytes.
    run_op(1'b0, 1'b1, 64'h400, 64'h1);
    run_op(1'b1, 1'b0, 64'h0, 64'd0);
    chk("wrap_ld", rdata, 64'h1);

    // Conflict then no-op (no-op must keep the zeroed rdata).
    run_op(1'b1, 1'b1, 64'h10, 64'h5);
    run_op(1'b0, 1'b0, 64'h18, 64'h6);
    chk("noop_rdata", rdata, 64'd0);

    // req held for six cycles: only the IDLE samples are taken.
    for (int i = 0; i < 6; i++) begin
      busy_addr[i] = 64'((16 + i) * 8);
      busy_dat[i]  = {$urandom, $urandom};
    end
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
      addr = busy_addr[i]; wdata = busy_dat[i];
      chk("busy_pattern", {63'd0, busy}, {63'd0, exp_busy[i]});
      if (done) n_done++;
      @(posedge clk);
    end
    @(negedge clk);
    req = 1'b0; mem_write = 1'b0;
    chk("busy_done_count", 64'(n_done), 64'd2);
    model_mem[idx_of(busy_addr[0])] = busy_dat[0];
    model_mem[idx_of(busy_addr[3])] = busy_dat[3];
    for (int i = 0; i < 6; i++) run_op(1'b1, 1'b0, busy_addr[i], 64'd0);

    // Reset during ACCESS of a store aborts it with no done.
    old8 = model_mem[1];
    @(negedge clk);
    req = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = 64'h8; wdata = ~old8;
    @(posedge clk); #1;
    req = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_err", {63'd0, err}, 64'd0);
    chk("midrst_rdata", rdata, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 64'd0;
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_no_done", 64'(n_done), 64'd0);
    run_op(1'b1, 1'b0, 64'h8, 64'd0);
    chk("midrst_ld", rdata, old8);

    // Randomized traffic, biased towards aligned ld/sd with junk upper bits.
    for (int n = 0; n < 300; n++) begin
      logic [63:0] a;
      int          kind;
      kind = int'($urandom_range(0, 9));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) a[2:0] = 3'd0;
      case (kind)
        0:       run_op(1'b1, 1'b1, a, {$urandom, $urandom});
        1:       run_op(1'b0, 1'b0, a, {$urandom, $urandom});
        2, 3, 4: run_op(1'b0, 1'b1, a, {$urandom, $urandom});
        default: run_op(1'b1, 1'b0, a, 64'd0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
